// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory-stage load/store unit: funct3 sizes, FSM states,
// and the size decode used by the top level and the load extender.
package mem_access_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Unassigned encodings (3, 6, 7) fall through to a full word.
    function automatic size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: f3_size = SZ_B;
            F3_LH, F3_LHU: f3_size = SZ_H;
            default:       f3_size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load lane select and sign/zero extension; funct3[2] set means unsigned.
module load_extend
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            addr_lo,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sext;

    always_comb begin
        byte_lane = rdata[{addr_lo, 3'b000} +: 8];
        half_lane = addr_lo[1] ? rdata[16 +: 16] : rdata[0 +: 16];
        sext      = ~funct3[2];
        case (f3_size(funct3))
            SZ_B:    data_out = {{(DATA_WIDTH-8){byte_lane[7] & sext}}, byte_lane};
            SZ_H:    data_out = {{(DATA_WIDTH-16){half_lane[15] & sext}}, half_lane};
            default: data_out = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns EX/MEM memory control into a valid/ready bus
// access and stalls the pipeline until it completes. Optional MEM_MISALIGN_CHECK_EN.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead_in,
    input  logic                  MemWrite_in,
    input  logic [2:0]            funct3_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] store_data_in,
    output logic                  stall_out,
    output logic [DATA_WIDTH-1:0] load_data_out,
    output logic                  misalign_out,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [3:0]            dmem_wstrb,
    input  logic                  dmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata
);

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
    logic [DATA_WIDTH-1:0] load_q, load_d;
    logic [DATA_WIDTH-1:0] ext_data;
    logic                  req_in;
    logic                  stall;

`ifdef MEM_MISALIGN_CHECK_EN
    logic  mis_q, mis_d;
    logic  in_mis;
    size_e in_size;

    always_comb begin
        in_size = f3_size(funct3_in);
        in_mis  = ((in_size == SZ_H) && addr_in[0]) ||
                  ((in_size == SZ_W) && (addr_in[1:0] != 2'b00));
    end
`endif

    assign req_in = MemRead_in | MemWrite_in;

    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
        .rdata    (dmem_rdata),
        .addr_lo  (addr_q[1:0]),
        .funct3   (f3_q),
        .data_out (ext_data)
    );

    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        f3_d           = f3_q;
        addr_d         = addr_q;
        sdata_d        = sdata_q;
        load_d         = load_q;
        stall          = 1'b0;
        dmem_req_valid = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        mis_d          = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_in) begin
                    stall   = 1'b1;
                    we_d    = MemWrite_in;
                    f3_d    = funct3_in;
                    addr_d  = addr_in;
                    sdata_d = store_data_in;
`ifdef MEM_MISALIGN_CHECK_EN
                    if (in_mis) begin
                        state_d = ST_DONE;
                        mis_d   = 1'b1;
                        if (!MemWrite_in)
                            load_d = '0;
                    end else begin
                        state_d = ST_REQ;
                    end
`else
                    state_d = ST_REQ;
`endif
                end
            end
            ST_REQ: begin
                stall          = 1'b1;
                dmem_req_valid = 1'b1;
                if (dmem_req_ready)
                    state_d = we_q ? ST_DONE : ST_RESP;
            end
            ST_RESP: begin
                stall = 1'b1;
                if (dmem_rsp_valid) begin
                    load_d  = ext_data;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Low address bits are never cleared in the latch: the bus address drops
    // [1:0] and lane/strobe logic only looks at the bits that matter per size.
    always_comb begin
        dmem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        case (f3_size(f3_q))
            SZ_B: begin
                dmem_wstrb = 4'b0001 << addr_q[1:0];
                dmem_wdata = {(DATA_WIDTH/8){sdata_q[7:0]}};
            end
            SZ_H: begin
                dmem_wstrb = 4'b0011 << {addr_q[1], 1'b0};
                dmem_wdata = {(DATA_WIDTH/16){sdata_q[15:0]}};
            end
            default: begin
                dmem_wstrb = 4'b1111;
                dmem_wdata = sdata_q;
            end
        endcase
        if (!we_q)
            dmem_wstrb = 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            sdata_q <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            load_q  <= load_d;
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mis_q <= 1'b0;
        else     mis_q <= mis_d;
    end
    assign misalign_out = mis_q;
`else
    assign misalign_out = 1'b0;
`endif

    // Reset forces stall low even while EX/MEM still presents a request.
    assign stall_out     = stall & ~rst;
    assign dmem_we       = we_q;
    assign load_data_out = load_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: scoreboarded bus requests plus load results.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_in, MemWrite_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in, store_data_in;
    logic        stall_out;
    logic [31:0] load_data_out;
    logic        misalign_out;
    logic        dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    req_t exp_q[$];

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .MemRead_in     (MemRead_in),
        .MemWrite_in    (MemWrite_in),
        .funct3_in      (funct3_in),
        .addr_in        (addr_in),
        .store_data_in  (store_data_in),
        .stall_out      (stall_out),
        .load_data_out  (load_data_out),
        .misalign_out   (misalign_out),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered just after a negedge with the unit in IDLE; leaves one cycle after DONE.
    task automatic run_op(input string name, input bit st, input bit ld, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input int rdy_wait, input int rsp_wait, input logic [31:0] rd,
                          input bit has_req, input logic [31:0] e_addr, input logic [3:0] e_strb,
                          input logic [31:0] e_wdata, input bit chk_ld, input logic [31:0] e_ld,
                          input int e_stall, input bit e_mis);
        int  stalls    = 0;
        int  req_seen  = 0;
        int  resp_seen = 0;
        bit  hs        = 0;
        bit  done      = 0;
        req_t r;
        MemWrite_in   = st;
        MemRead_in    = ld;
        funct3_in     = f3;
        addr_in       = a;
        store_data_in = sd;
        if (has_req) begin
            r.addr = e_addr; r.we = st; r.wstrb = e_strb; r.wdata = e_wdata;
            exp_q.push_back(r);
        end
        for (int cyc = 0; cyc < 60; cyc++) begin
            dmem_req_ready = (req_seen >= rdy_wait);
            dmem_rsp_valid = hs && !st && (resp_seen >= rsp_wait);
            dmem_rdata     = dmem_rsp_valid ? rd : 32'h5A5A_5A5A;
            #1;
            if (!stall_out) begin
                done = 1;
                break;
            end
            stalls++;
            if (dmem_req_valid) begin
                if (exp_q.size() == 0) begin
                    chk({name, " spurious_req"}, {31'd0, dmem_req_valid}, 32'd0);
                end else begin
                    chk({name, " addr"}, dmem_addr, exp_q[0].addr);
                    chk({name, " we"}, {31'd0, dmem_we}, {31'd0, exp_q[0].we});
                    chk({name, " wstrb"}, {28'd0, dmem_wstrb}, {28'd0, exp_q[0].wstrb});
                    if (st) chk({name, " wdata"}, dmem_wdata, exp_q[0].wdata);
                    if (dmem_req_ready) begin
                        void'(exp_q.pop_front());
                        hs = 1;
                    end
                end
                req_seen++;
            end else if (hs) begin
                resp_seen++;
            end
            @(negedge clk);
        end
        if (!done) chk({name, " timeout_stall"}, {31'd0, stall_out}, 32'd0);
        chk({name, " stall_cycles"}, stalls, e_stall);
        chk({name, " handshake"}, {31'd0, hs}, {31'd0, has_req});
        chk({name, " misalign"}, {31'd0, misalign_out}, {31'd0, e_mis});
        if (chk_ld) chk({name, " load_data"}, load_data_out, e_ld);
        MemRead_in = 0; MemWrite_in = 0; dmem_rsp_valid = 0;
        @(negedge clk);
        #1;
        chk({name, " idle_stall"}, {31'd0, stall_out}, 32'd0);
        chk({name, " idle_req_valid"}, {31'd0, dmem_req_valid}, 32'd0);
    endtask

    initial begin
        rst = 1; MemRead_in = 0; MemWrite_in = 0; funct3_in = 0; addr_in = 0;
        store_data_in = 0; dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0;
        @(negedge clk); #1;
        chk("rst stall", {31'd0, stall_out}, 32'd0);
        chk("rst req_valid", {31'd0, dmem_req_valid}, 32'd0);
        chk("rst load", load_data_out, 32'd0);
        chk("rst misalign", {31'd0, misalign_out}, 32'd0);
        chk("rst addr", dmem_addr, 32'd0);
        chk("rst wstrb_we", {27'd0, dmem_we, dmem_wstrb}, 32'd0);
        chk("rst wdata", dmem_wdata, 32'd0);
        rst = 0;
        @(negedge clk);

        //     name   st ld f3    addr          sdata         rdy rsp rdata          req e_addr        strb     e_wdata        chk e_ld           stl mis
        run_op("SW",   1, 0, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h0,         1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 1, 32'h0,         2, 0);
        run_op("SB",   1, 0, 3'd0, 32'h0000_0103, 32'h0000_00A5, 0, 0, 32'h0,         1, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 0, 32'h0,         2, 0);
        run_op("SH",   1, 0, 3'd1, 32'h0000_0102, 32'h1234_BEEF, 1, 0, 32'h0,         1, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0,         3, 0);
        run_op("LB",   0, 1, 3'd0, 32'h0000_0102, 32'h0,         0, 0, 32'h0080_0000, 1, 32'h0000_0100, 4'b0000, 32'h0,         1, 32'hFFFF_FF80, 3, 0);
        run_op("LBU",  0, 1, 3'd4, 32'h0000_0102, 32'h0,         0, 0, 32'h0080_0000, 1, 32'h0000_0100, 4'b0000, 32'h0,         1, 32'h0000_0080, 3, 0);
        run_op("SWkeep",1,0, 3'd2, 32'h0000_0104, 32'h0BAD_F00D, 0, 0, 32'h0,         1, 32'h0000_0104, 4'b1111, 32'h0BAD_F00D, 1, 32'h0000_0080, 2, 0);
        run_op("LHbp", 0, 1, 3'd1, 32'h0000_0102, 32'h0,         3, 2, 32'h7FFF_0000, 1, 32'h0000_0100, 4'b0000, 32'h0,         1, 32'h0000_7FFF, 8, 0);
        run_op("LHU",  0, 1, 3'd5, 32'h0000_0200, 32'h0,         0, 0, 32'h1234_8001, 1, 32'h0000_0200, 4'b0000, 32'h0,         1, 32'h0000_8001, 3, 0);
        run_op("LH",   0, 1, 3'd1, 32'h0000_0200, 32'h0,         0, 1, 32'h1234_8001, 1, 32'h0000_0200, 4'b0000, 32'h0,         1, 32'hFFFF_8001, 4, 0);
        run_op("LB3",  0, 1, 3'd0, 32'h0000_0301, 32'h0,         0, 0, 32'h1122_F344, 1, 32'h0000_0300, 4'b0000, 32'h0,         1, 32'hFFFF_FFF3, 3, 0);
        run_op("F3_3", 0, 1, 3'd3, 32'h0000_0108, 32'h0,         0, 0, 32'hCAFE_F00D, 1, 32'h0000_0108, 4'b0000, 32'h0,         1, 32'hCAFE_F00D, 3, 0);
        run_op("RdWr", 1, 1, 3'd2, 32'h0000_010C, 32'h0000_0055, 0, 0, 32'h0,         1, 32'h0000_010C, 4'b1111, 32'h0000_0055, 1, 32'hCAFE_F00D, 2, 0);
`ifdef MEM_MISALIGN_CHECK_EN
        run_op("misLW",0, 1, 3'd2, 32'h0000_0101, 32'h0,         0, 0, 32'h1122_3344, 0, 32'h0,         4'b0000, 32'h0,         1, 32'h0,         1, 1);
        run_op("misSH",1, 0, 3'd1, 32'h0000_0101, 32'h0000_ABCD, 0, 0, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         1, 32'h0,         1, 1);
`else
        run_op("misLW",0, 1, 3'd2, 32'h0000_0101, 32'h0,         0, 0, 32'h1122_3344, 1, 32'h0000_0100, 4'b0000, 32'h0,         1, 32'h1122_3344, 3, 0);
        run_op("misSH",1, 0, 3'd1, 32'h0000_0101, 32'h0000_ABCD, 0, 0, 32'h0,         1, 32'h0000_0100, 4'b0011, 32'hABCD_ABCD, 1, 32'h1122_3344, 2, 0);
`endif

        // Reset while a load sits in REQ with ready low.
        MemRead_in = 1; funct3_in = 3'd2; addr_in = 32'h0000_0400;
        dmem_req_ready = 0; dmem_rsp_valid = 0;
        #1 chk("rstq idle_stall", {31'd0, stall_out}, 32'd1);
        @(negedge clk); #1;
        chk("rstq in_req", {31'd0, dmem_req_valid}, 32'd1);
        rst = 1;
        #1;
        chk("rstq req_drop", {31'd0, dmem_req_valid}, 32'd0);
        chk("rstq stall_drop", {31'd0, stall_out}, 32'd0);
        chk("rstq addr_clr", dmem_addr, 32'd0);
        chk("rstq load_clr", load_data_out, 32'd0);
        @(negedge clk);
        rst = 0; MemRead_in = 0;
        dmem_rsp_valid = 1; dmem_rdata = 32'hFFFF_FFFF;
        repeat (2) begin
            @(negedge clk); #1;
            chk("rstq late_rsp_load", load_data_out, 32'd0);
            chk("rstq late_rsp_stall", {31'd0, stall_out}, 32'd0);
        end
        dmem_rsp_valid = 0;
        @(negedge clk);
        run_op("post", 0, 1, 3'd4, 32'h0000_0503, 32'h0,         0, 0, 32'h9A00_0000, 1, 32'h0000_0500, 4'b0000, 32'h0,         1, 32'h0000_009A, 3, 0);

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit sitting directly downstream of the EX/MEM pipeline register and upstream of MEM/WB. Converts the registered memory control (MemRead/MemWrite, funct3 size, ALU address, rs2 store data) into a valid/ready data-memory bus transaction. Stalls the pipeline for the full duration of each access and returns a size-extended load result to MEM/WB.

## Interface
- `DATA_WIDTH`, default 32: data bus and register width; equals `` `REG_DATA_WIDTH ``.
- `ADDR_WIDTH`, default 32: byte address width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `MemRead_in` input 1: load request from EX/MEM.
- `MemWrite_in` input 1: store request from EX/MEM.
- `funct3_in` input 3: access size and sign (0 B, 1 H, 2 W, 4 BU, 5 HU).
- `addr_in` input ADDR_WIDTH: byte address, the EX/MEM ALU result.
- `store_data_in` input DATA_WIDTH: rs2 value from EX/MEM.
- `stall_out` output 1: holds PC, IF/ID, ID/EX and EX/MEM while high.
- `load_data_out` output DATA_WIDTH: extended load result, registered.
- `misalign_out` output 1: one-cycle misaligned-access flag; tied to 0 when compiled out.
- `dmem_req_valid` output 1: bus request valid.
- `dmem_req_ready` input 1: bus accepts the request.
- `dmem_we` output 1: 1 for a store, 0 for a load.
- `dmem_addr` output ADDR_WIDTH: word-aligned address, with bits [1:0] equal to 0.
- `dmem_wdata` output DATA_WIDTH: store data replicated across byte lanes.
- `dmem_wstrb` output 4: byte-lane write strobes; all 0 for loads.
- `dmem_rsp_valid` input 1: read data valid.
- `dmem_rdata` input DATA_WIDTH: read data word.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- **IDLE**
  - On MemRead_in or MemWrite_in, latch addr, funct3, store data and op, then go to REQ.
  - stall_out is combinationally 1 in this cycle.
  - If both MemRead_in and MemWrite_in are set, the store wins.
- **REQ**
  - dmem_req_valid=1; request fields are driven from the latched values only.
  - On dmem_req_ready: a store goes to DONE, a load goes to RESP.
  - dmem_req_valid stays high, with fields stable, until ready is seen.
- **RESP**
  - Wait for dmem_rsp_valid.
  - On valid, extract the lane, extend it into load_data_out, and go to DONE.
- **DONE**
  - stall_out=0 for exactly one cycle, so EX/MEM advances; then go to IDLE.
- stall_out=1 in IDLE-with-request, REQ and RESP. It is 0 in DONE and in IDLE with no request.
- **Strobes**
  - SB: 4'b0001<<addr[1:0].
  - SH: 4'b0011<<{addr[1],1'b0}.
  - SW: 4'b1111.
- **Write data**
  - Byte replicated ×4; half replicated ×2; word as-is.
- **Load extract**
  - The lane is selected by addr[1:0] or addr[1].
  - B/H are sign-extended; BU/HU are zero-extended.
- funct3 values 3, 6 and 7 are treated as word.
- dmem_rsp_valid outside RESP is ignored.
- load_data_out holds its value until the next load completes; stores do not modify it.

## Timing
- Reset: state=IDLE. All outputs are 0, including stall_out, dmem_req_valid, load_data_out and misalign_out; latched registers are cleared.
- Reset mid-transaction abandons the access and drops dmem_req_valid immediately.
- Store latency with ready held high: 3 cycles, IDLE → REQ → DONE.
- Load latency with ready held high and rsp the next cycle: 4 cycles.
- Each cycle of ready/rsp backpressure adds one cycle.
- Bus contract: rsp_valid arrives no earlier than the cycle after the request handshake.
- Back-to-back memory ops: the DONE cycle is followed by IDLE sampling the new EX/MEM contents. There is no bubble beyond the DONE cycle.

## Configuration
- Macro: `MEM_MISALIGN_CHECK_EN`.
- **Defined**
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, issues no bus request.
  - The FSM goes IDLE → DONE.
  - misalign_out=1 during DONE.
  - A misaligned load sets load_data_out to 0.
- **Undefined**
  - Offending low address bits are cleared: a half uses addr[0]=0, a word uses addr[1:0]=0.
  - The access proceeds normally.
  - misalign_out is constant 0.

## Structure
- In the shared `const.v`:
  - funct3 size encodings as `` `F3_LB ``, `` `F3_LH ``, `` `F3_LW ``, `` `F3_LBU ``, `` `F3_LHU ``.
  - FSM state encodings.
  - The existing width macros.
- Sub-module `load_extend`: combinational lane select plus sign/zero extension, taking (rdata, addr[1:0], funct3) and producing extended data. Instantiated once.

## Test plan
- **SW:** addr 0x100, data 0xDEADBEEF, ready high → req with wstrb=1111, wdata=0xDEADBEEF; stall for 2 cycles, then released.
- **SB:** addr 0x103, data 0x000000A5 → dmem_addr 0x100, wstrb=1000, wdata=0xA5A5A5A5.
- **LB then LBU:** addr 0x102, rdata 0x00800000 → load_data_out 0xFFFFFF80, then 0x00000080.
- **Backpressure:** LH at 0x102, ready low for 3 cycles, rsp 2 cycles later with rdata 0x7FFF0000 → fields stable while waiting; total 8 stall cycles; result 0x00007FFF.
- **Misaligned LW at 0x101:**
  - With the macro: no req_valid, misalign_out pulse, result 0.
  - Without the macro: dmem_addr 0x100.
- **Reset asserted in REQ:** req_valid and stall drop asynchronously; state returns to IDLE; a later rsp_valid is ignored.
